bit_permute_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 32-bit bit-reversal block in the FPU datapath.
- Supports four permutation modes: full bit reverse, byte swap, bit reverse within each byte, and pass-through.
- Also produces the leading-zero count of the permuted result. In full bit-reverse mode this is the trailing-zero count of the input, which the FPU normaliser and rounder use.
- Sits between operand staging and the normalisation shifter, with valid/ready handshakes on both sides.

---
 rtl/bit_permute_pipe.sv | 142 ++++++++++++++
 tb/tb_bit_permute_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_permute_pipe.sv
// Pipelined bit permuter (reverse / byte swap / per-byte reverse / pass) with leading-zero count.
// Optional out_par (XOR of out_data) is built when BIT_PERMUTE_PARITY_EN is defined.
module bit_permute_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [1:0]             in_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(WIDTH):0] out_lzc,
    output logic [TAG_W-1:0]       out_tag
`ifdef BIT_PERMUTE_PARITY_EN
    ,
    output logic                   out_par
`endif
);

    localparam int LZW    = $clog2(WIDTH) + 1;
    localparam int NBYTES = WIDTH / 8;

    function automatic logic [WIDTH-1:0] permute(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] m);
        logic [WIDTH-1:0] r;
        r = d;
        unique case (m)
            2'b00: for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
            2'b01: for (int k = 0; k < NBYTES; k++) r[8*k +: 8] = d[8*(NBYTES-1-k) +: 8];
            2'b10: begin
                for (int k = 0; k < NBYTES; k++) begin
                    for (int j = 0; j < 8; j++) r[8*k+j] = d[8*k+7-j];
                end
            end
            2'b11: r = d;
        endcase
        return r;
    endfunction

    // Scanning upward lets the highest set bit win; all-zero keeps WIDTH.
    function automatic logic [LZW-1:0] lzc(input logic [WIDTH-1:0] d);
        logic [LZW-1:0] c;
        c = LZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) c = LZW'(WIDTH - 1 - i);
        end
        return c;
    endfunction

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [LZW-1:0]   out_lzc_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             fin_en;
    logic             fin_load_valid;
    logic [WIDTH-1:0] fin_data_d;
    logic [LZW-1:0]   fin_lzc_d;
    logic [TAG_W-1:0] fin_tag_d;

    assign fin_en = ~out_valid_q | out_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic             s1_valid_q;
            logic [WIDTH-1:0] s1_data_q;
            logic [TAG_W-1:0] s1_tag_q;

            assign in_ready       = ~s1_valid_q | fin_en;
            assign fin_load_valid = s1_valid_q;
            assign fin_data_d     = s1_data_q;
            assign fin_lzc_d      = lzc(s1_data_q);
            assign fin_tag_d      = s1_tag_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    s1_tag_q   <= '0;
                end else if (in_ready) begin
                    s1_valid_q <= in_valid;
                    if (in_valid) begin
                        s1_data_q <= permute(in_data, in_mode);
                        s1_tag_q  <= in_tag;
                    end
                end
            end
        end else begin : g_one
            logic [WIDTH-1:0] perm;

            assign perm           = permute(in_data, in_mode);
            assign in_ready       = fin_en;
            assign fin_load_valid = in_valid;
            assign fin_data_d     = perm;
            assign fin_lzc_d      = lzc(perm);
            assign fin_tag_d      = in_tag;
        end
    endgenerate

    // Final stage only loads on a real item, so stalled outputs stay put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lzc_q   <= '0;
            out_tag_q   <= '0;
        end else if (fin_en) begin
            out_valid_q <= fin_load_valid;
            if (fin_load_valid) begin
                out_data_q <= fin_data_d;
                out_lzc_q  <= fin_lzc_d;
                out_tag_q  <= fin_tag_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lzc   = out_lzc_q;
    assign out_tag   = out_tag_q;

`ifdef BIT_PERMUTE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (fin_en && fin_load_valid) begin
            par_q <= ^fin_data_d;
        end
    end

    assign out_par = par_q;
`endif

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Randomized self-checking bench for bit_permute_pipe (WIDTH=32, STAGES=2).
module tb_bit_permute_pipe;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [5:0]    out_lzc;
    logic [TW-1:0] out_tag;
`ifdef BIT_PERMUTE_PARITY_EN
    logic          out_par;
`endif

    int tests = 0;
    int fails = 0;

    bit_permute_pipe #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lzc   (out_lzc),
        .out_tag   (out_tag)
`ifdef BIT_PERMUTE_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: streaming operators give bit reverse and byte swap directly;
    // per-byte reverse is the bit reverse of the byte-swapped word.
    function automatic logic [W-1:0] model_perm(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] br;
        logic [W-1:0] bs;
        logic [W-1:0] pb;
        br = {<<{d}};
        bs = {<<8{d}};
        pb = {<<{bs}};
        case (m)
            2'd0:    return br;
            2'd1:    return bs;
            2'd2:    return pb;
            default: return d;
        endcase
    endfunction

    function automatic int model_lzc(input logic [W-1:0] d);
        int n;
        n = 0;
        while (n < W && d[W-1-n] == 1'b0) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_lzc !== '0 || out_tag !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%b data=%h lzc=%0d tag=%0d, want 0 0 0 0",
                     out_valid, out_data, out_lzc, out_tag);
        end
`ifdef BIT_PERMUTE_PARITY_EN
        tests++;
        if (out_par !== 1'b0) begin
            fails++;
            $display("FAIL reset_par: got %b want 0", out_par);
        end
`endif
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]  din [5] = '{32'h00000001, 32'h12345678, 32'h01800F00, 32'h00000000, 32'h00010000};
        logic [1:0]    dm  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
        logic [W-1:0]  dout[5] = '{32'h80000000, 32'h78563412, 32'h8001F000, 32'h00000000, 32'h00010000};
        int            dl  [5] = '{0, 1, 0, 32, 15};
        logic [TW-1:0] dt  [5] = '{4'd3, 4'd5, 4'd9, 4'd12, 4'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = din[i]; in_mode = dm[i]; in_tag = dt[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; in_data = ~din[i]; in_mode = ~dm[i]; in_tag = ~dt[i];
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL dir%0d_early: out_valid=%b after 1 cycle, want 0", i, out_valid);
            end
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== dout[i] || out_lzc !== 6'(dl[i])
                || out_tag !== dt[i]) begin
                fails++;
                $display("FAIL dir%0d: valid=%b data=%h lzc=%0d tag=%0d, want 1 %h %0d %0d",
                         i, out_valid, out_data, out_lzc, out_tag, dout[i], dl[i], dt[i]);
            end
`ifdef BIT_PERMUTE_PARITY_EN
            tests++;
            if (out_par !== ^dout[i]) begin
                fails++;
                $display("FAIL dir%0d_par: got %b want %b", i, out_par, ^dout[i]);
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [W-1:0]  d[3];
        logic [1:0]    m[3];
        logic [W-1:0]  e[3];
        int            idx;
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom; m[i] = 2'($urandom_range(0, 3)); e[i] = model_perm(d[i], m[i]);
        end
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                tests++;
                if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_data !== e[0]
                    || out_lzc !== 6'(model_lzc(e[0]))) begin
                    fails++;
                    $display("FAIL stall_hold c%0d: valid=%b tag=%0d data=%h lzc=%0d, want 1 1 %h %0d",
                             c, out_valid, out_tag, out_data, out_lzc, e[0], model_lzc(e[0]));
                end
            end
            in_valid = 1'b1; in_data = d[idx]; in_mode = m[idx]; in_tag = 4'(idx + 1);
            out_ready = 1'b0;
            #1;
            tests++;
            if (in_ready !== (c < 2)) begin
                fails++;
                $display("FAIL stall_in_ready c%0d: got %b want %b", c, in_ready, c < 2);
            end
            if (in_ready === 1'b1) idx++;
        end
        tests++;
        if (idx != 2) begin
            fails++;
            $display("FAIL stall_accepted: got %0d items want 2", idx);
        end
        for (int c = 6; c < 10; c++) begin
            @(negedge clk);
            if (c < 9) begin
                tests++;
                if (out_valid !== 1'b1 || out_tag !== 4'(c - 5) || out_data !== e[c-6]) begin
                    fails++;
                    $display("FAIL stall_drain c%0d: valid=%b tag=%0d data=%h, want 1 %0d %h",
                             c, out_valid, out_tag, out_data, c - 5, e[c-6]);
                end
            end else begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_empty: out_valid=%b want 0", out_valid);
                end
            end
            out_ready = 1'b1;
            if (c == 6 && idx == 2) begin
                in_valid = 1'b1; in_data = d[2]; in_mode = m[2]; in_tag = 4'd3;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  q_data[$];
        logic [TW-1:0] q_tag[$];
        logic [W-1:0]  d;
        logic [1:0]    m;
        logic [TW-1:0] t;
        int sent = 0, got = 0, first = -1, last = -1;
        for (int c = 0; c < 40 && got < 16; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                tests++;
                if (q_data.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_spurious: output tag=%0d with nothing pending", out_tag);
                end else begin
                    if (out_data !== q_data[0] || out_tag !== q_tag[0]
                        || out_lzc !== 6'(model_lzc(q_data[0]))) begin
                        fails++;
                        $display("FAIL b2b_item%0d: data=%h lzc=%0d tag=%0d, want %h %0d %0d",
                                 got, out_data, out_lzc, out_tag, q_data[0],
                                 model_lzc(q_data[0]), q_tag[0]);
                    end
`ifdef BIT_PERMUTE_PARITY_EN
                    tests++;
                    if (out_par !== ^q_data[0]) begin
                        fails++;
                        $display("FAIL b2b_par%0d: got %b want %b", got, out_par, ^q_data[0]);
                    end
`endif
                    void'(q_data.pop_front());
                    void'(q_tag.pop_front());
                    if (first < 0) first = c;
                    last = c;
                    got++;
                end
            end
            out_ready = 1'b1;
            if (sent < 16) begin
                d = $urandom; m = 2'($urandom_range(0, 3)); t = 4'($urandom);
                in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
                #1;
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_in_ready item%0d: got %b want 1", sent, in_ready);
                end else begin
                    q_data.push_back(model_perm(d, m));
                    q_tag.push_back(t);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (got != 16 || last - first != 15) begin
            fails++;
            $display("FAIL b2b_count: got %0d outputs over %0d cycles, want 16 over 15",
                     got, last - first);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] d;
        logic [W-1:0] e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = $urandom; in_mode = 2'd1; in_tag = 4'(i + 7);
            out_ready = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: out_valid=%b want 1 before reset", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || out_lzc !== '0) begin
            fails++;
            $display("FAIL areset_now: valid=%b data=%h tag=%0d lzc=%0d, want all 0",
                     out_valid, out_data, out_tag, out_lzc);
        end
`ifdef BIT_PERMUTE_PARITY_EN
        tests++;
        if (out_par !== 1'b0) begin
            fails++;
            $display("FAIL areset_par: got %b want 0", out_par);
        end
`endif
        @(negedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL areset_stale c%0d: out_valid=%b tag=%0d, want 0", c, out_valid, out_tag);
            end
        end
        d = $urandom;
        e = model_perm(d, 2'd2);
        in_valid = 1'b1; in_data = d; in_mode = 2'd2; in_tag = 4'd11;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== e || out_tag !== 4'd11) begin
            fails++;
            $display("FAIL areset_after: valid=%b data=%h tag=%0d, want 1 %h 11",
                     out_valid, out_data, out_tag, e);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
